synchronous_fifo_ext: RTL and testbench

SYNCHRONOUS_FIFO_EXT -- requirements
Module: synchronous_fifo_ext

---
 rtl/synchronous_fifo_ext.sv | 85 ++++++++
 tb/tb_synchronous_fifo_ext.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/synchronous_fifo_ext.sv
// Single-clock FIFO with occupancy/threshold flags, sticky overflow/underflow
// errors and a selectable registered or first-word-fall-through read port.
module synchronous_fifo_ext #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int AF_THRESH  = DEPTH - 2,
   parameter int AE_THRESH  = 2,
   parameter int FWFT       = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       w_en,
   input  logic                       r_en,
   input  logic [DATA_WIDTH-1:0]      data_in,
   output logic [DATA_WIDTH-1:0]      data_out,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow,
   input  logic                       clr_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]         count_q, count_d;
   logic [DATA_WIDTH-1:0] dout_q;
   logic                  wr_acc, rd_acc;

   // A write into a full FIFO is still accepted when a read frees a slot the same cycle.
   assign rd_acc = r_en & ~empty;
   assign wr_acc = w_en & (~full | rd_acc);

   assign full         = (count_q == CW'(DEPTH));
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= CW'(AF_THRESH));
   assign almost_empty = (count_q <= CW'(AE_THRESH));
   assign count        = count_q;

   // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      count_d = count_q;
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count_q   <= '0;
         dout_q    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         count_q <= count_d;
         if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
         if (rd_acc) begin
            rd_ptr <= rd_ptr + AW'(1);
            dout_q <= mem[rd_ptr];
         end
         // A set condition coinciding with clr_err keeps the flag high.
         overflow  <= (w_en & full & ~rd_acc) | (overflow & ~clr_err);
         underflow <= (r_en & empty) | (underflow & ~clr_err);
      end
   end

   // NOTE: the storage array has no reset; stale words are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= data_in;
   end

   // In FWFT mode the head word is shown directly; when empty, the last popped word is held.
   assign data_out = (FWFT != 0 && !empty) ? mem[rd_ptr] : dout_q;

endmodule

// File: tb/tb_synchronous_fifo_ext.sv
// Randomized and directed bench for synchronous_fifo_ext, running a registered-read
// and an FWFT instance side by side against a queue-based reference model.
module tb_synchronous_fifo_ext;

   localparam int DW    = 8;
   localparam int DEPTH = 8;
   localparam int AF    = 6;
   localparam int AE    = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          w_en = 1'b0, r_en = 1'b0, clr_err = 1'b0;
   logic [DW-1:0] data_in = '0;

   logic [DW-1:0] dout0, dout1;
   logic          full0, empty0, af0, ae0, ov0, uf0;
   logic          full1, empty1, af1, ae1, ov1, uf1;
   logic [3:0]    count0, count1;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [DW-1:0] q[$];
   logic [DW-1:0] last_pop = '0;
   logic          ov_m = 1'b0, uf_m = 1'b0;

   always #5 clk = ~clk;

   synchronous_fifo_ext #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) u_reg (
      .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .data_in(data_in), .data_out(dout0),
      .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0), .count(count0),
      .overflow(ov0), .underflow(uf0), .clr_err(clr_err)
   );

   synchronous_fifo_ext #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) u_fwft (
      .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .data_in(data_in), .data_out(dout1),
      .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1), .count(count1),
      .overflow(ov1), .underflow(uf1), .clr_err(clr_err)
   );

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic check_all();
      int n = q.size();
      check("count0",  32'(count0), 32'(n));
      check("count1",  32'(count1), 32'(n));
      check("full0",   32'(full0),  32'(n == DEPTH));
      check("full1",   32'(full1),  32'(n == DEPTH));
      check("empty0",  32'(empty0), 32'(n == 0));
      check("empty1",  32'(empty1), 32'(n == 0));
      check("afull0",  32'(af0),    32'(n >= AF));
      check("afull1",  32'(af1),    32'(n >= AF));
      check("aempty0", 32'(ae0),    32'(n <= AE));
      check("aempty1", 32'(ae1),    32'(n <= AE));
      check("ovf0",    32'(ov0),    32'(ov_m));
      check("ovf1",    32'(ov1),    32'(ov_m));
      check("udf0",    32'(uf0),    32'(uf_m));
      check("udf1",    32'(uf1),    32'(uf_m));
      check("dout_reg", 32'(dout0), 32'(last_pop));
      if (n != 0) check("dout_fwft", 32'(dout1), 32'(q[0]));
   endtask

   // One clock: apply inputs, advance the model by the FIFO rules, compare after the edge.
   task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input logic clr);
      bit was_full, was_empty, rd_ok, wr_ok;
      w_en = w; r_en = r; data_in = d; clr_err = clr;
      @(posedge clk);
      #1;
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      rd_ok = r && !was_empty;
      wr_ok = w && (!was_full || rd_ok);
      ov_m = (w && was_full && !rd_ok) || (ov_m && !clr);
      uf_m = (r && was_empty) || (uf_m && !clr);
      if (rd_ok) last_pop = q.pop_front();
      if (wr_ok) q.push_back(d);
      check_all();
   endtask

   task automatic model_reset();
      q.delete();
      last_pop = '0;
      ov_m = 1'b0;
      uf_m = 1'b0;
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      rst = 1'b0;

      // Fill 0x01..0x08, then drain in order.
      for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, DW'(i), 1'b0);
      // Overflow on full, then clear it.
      step(1'b1, 1'b0, 8'hEE, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      // Simultaneous write/read while full.
      step(1'b1, 1'b1, 8'hAA, 1'b0);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
      check("last_word_aa", 32'(dout0), 32'h0000_00AA);
      // Simultaneous write/read while empty: underflow, 0x55 stored.
      step(1'b1, 1'b1, 8'h55, 1'b0);
      check("fwft_55", 32'(dout1), 32'h0000_0055);
      // Underflow set together with clr_err must stay set.
      step(1'b0, 1'b1, 8'h00, 1'b0);
      step(1'b0, 1'b1, 8'h00, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b1);

      // Wrap: keep occupancy in 3..5 while 12 writes go through.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'(8'h10 + i), 1'b0);
      for (int i = 0; i < 12; i++) begin
         step(1'b1, (i % 2) == 1, DW'(8'h20 + i), 1'b0);
         if (i % 2 == 1) step(1'b0, 1'b1, 8'h00, 1'b0);
      end

      // Asynchronous reset mid-operation with count 5.
      while (q.size() < 5) step(1'b1, 1'b0, DW'($urandom), 1'b0);
      while (q.size() > 5) step(1'b0, 1'b1, 8'h00, 1'b0);
      w_en = 1'b0; r_en = 1'b0;
      rst = 1'b1;
      #2;
      model_reset();
      check_all();
      check("rst_dout_fwft", 32'(dout1), 32'h0);
      rst = 1'b0;
      step(1'b1, 1'b0, 8'h33, 1'b0);
      step(1'b0, 1'b1, 8'h00, 1'b0);
      check("post_rst_33", 32'(dout0), 32'h0000_0033);

      // Random phases with shifting write/read bias so full and empty are both visited.
      for (int p = 0; p < 8; p++) begin
         int wb = (p % 2 == 0) ? 75 : 25;
         for (int i = 0; i < 150; i++)
            step(($urandom % 100) < wb, ($urandom % 100) < (100 - wb),
                 DW'($urandom), ($urandom % 16) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
